// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates stall/flush requests across the five
// inter-stage registers, times fixed-latency divides and redirects the PC.
module pipe_ctrl #(
  parameter int          DIV_LATENCY = 32,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_use_i,
  input  logic        exe_div_start_i,
  input  logic        mem_bus_wait_i,
  input  logic        excp_valid_i,
  input  logic        excp_eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        div_done_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DIV_BUSY   = 2'd1,
    FLUSH_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(DIV_LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;

  logic redirect;
  logic div_hold;
  logic div_finish;

  assign redirect   = excp_valid_i | excp_eret_i;
  // A divide occupies EXE from the issuing cycle until its counter reaches zero.
  assign div_hold   = ((state_q == DIV_BUSY) && (div_cnt_q != 8'd0)) ||
                      ((state_q == RUN) && exe_div_start_i);
  assign div_finish = (state_q == DIV_BUSY) && (div_cnt_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (redirect) begin
      state_d   = FLUSH_HOLD;
      div_cnt_d = 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (exe_div_start_i) begin
            state_d   = DIV_BUSY;
            div_cnt_d = DIV_RELOAD;
          end
        end
        DIV_BUSY: begin
          // The counter freezes while MEM is waiting, which also defers the done pulse.
          if (!mem_bus_wait_i) begin
            if (div_cnt_q == 8'd0) begin
              state_d = RUN;
            end else begin
              div_cnt_d = div_cnt_q - 8'd1;
            end
          end
        end
        FLUSH_HOLD: state_d = RUN;
        default: begin
          state_d   = RUN;
          div_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      div_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    stall_o        = 5'b00000;
    flush_o        = 5'b00000;
    new_pc_o       = 32'd0;
    new_pc_valid_o = 1'b0;
    div_done_o     = 1'b0;
    if (rst) begin
      stall_o = 5'b00000;
    end else if (redirect) begin
      flush_o        = 5'b11110;
      new_pc_valid_o = 1'b1;
      new_pc_o       = excp_valid_i ? EXC_VECTOR : cp0_epc_i;
    end else if (mem_bus_wait_i) begin
      stall_o = 5'b01111;
      flush_o = 5'b10000;
    end else if (div_hold) begin
      stall_o = 5'b00111;
      flush_o = 5'b01000;
    end else if (id_load_use_i && (state_q != FLUSH_HOLD)) begin
      // Hazards reported right after a flush belong to squashed instructions.
      stall_o = 5'b00011;
      flush_o = 5'b00100;
    end
    if (!rst && !redirect && !mem_bus_wait_i && div_finish) begin
      div_done_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one DUT with DIV_LATENCY=4 for the main
// scenarios, a second with DIV_LATENCY=1 for the minimum-latency boundary.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_load_use;
  logic        exe_div_start;
  logic        mem_bus_wait;
  logic        excp_valid;
  logic        excp_eret;
  logic [31:0] cp0_epc;

  logic [4:0]  stall4, flush4, stall1, flush1;
  logic [31:0] npc4, npc1;
  logic        npcv4, npcv1, done4, done1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [4:0] exp_stall, exp_flush;
  logic       exp_done;

  pipe_ctrl #(.DIV_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_load_use_i(id_load_use), .exe_div_start_i(exe_div_start),
    .mem_bus_wait_i(mem_bus_wait), .excp_valid_i(excp_valid), .excp_eret_i(excp_eret),
    .cp0_epc_i(cp0_epc), .stall_o(stall4), .flush_o(flush4), .new_pc_o(npc4),
    .new_pc_valid_o(npcv4), .div_done_o(done4)
  );

  pipe_ctrl #(.DIV_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_load_use_i(id_load_use), .exe_div_start_i(exe_div_start),
    .mem_bus_wait_i(mem_bus_wait), .excp_valid_i(excp_valid), .excp_eret_i(excp_eret),
    .cp0_epc_i(cp0_epc), .stall_o(stall1), .flush_o(flush1), .new_pc_o(npc1),
    .new_pc_valid_o(npcv1), .div_done_o(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_load_use   = 1'b0;
    exe_div_start = 1'b0;
    mem_bus_wait  = 1'b0;
    excp_valid    = 1'b0;
    excp_eret     = 1'b0;
    cp0_epc       = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #3;
    tests_run++; if (stall4 !== 5'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 00000", stall4); end
    tests_run++; if (flush4 !== 5'b0) begin tests_failed++; $display("FAIL reset_flush: got %b expected 00000", flush4); end
    tests_run++; if (npcv4 !== 1'b0 || npc4 !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got v=%b pc=%h expected v=0 pc=00000000", npcv4, npc4); end
    tests_run++; if (done4 !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done4); end
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (stall4 !== 5'b0 || flush4 !== 5'b0 || done4 !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: got stall=%b flush=%b done=%b expected 00000 00000 0", stall4, flush4, done4); end
    step();
  endtask

  task automatic test_load_use();
    id_load_use = 1'b1;
    @(negedge clk);
    tests_run++; if (stall4 !== 5'b00011) begin tests_failed++; $display("FAIL load_use_stall: got %b expected 00011", stall4); end
    tests_run++; if (flush4 !== 5'b00100) begin tests_failed++; $display("FAIL load_use_flush: got %b expected 00100", flush4); end
    step();
    id_load_use = 1'b0;
    @(negedge clk);
    tests_run++; if (stall4 !== 5'b0 || flush4 !== 5'b0) begin tests_failed++; $display("FAIL load_use_after: got stall=%b flush=%b expected 00000 00000", stall4, flush4); end
    step();
  endtask

  task automatic test_divide();
    for (int c = 0; c < 6; c++) begin
      exe_div_start = (c == 0);
      @(negedge clk);
      exp_stall = (c < 4) ? 5'b00111 : 5'b00000;
      exp_flush = (c < 4) ? 5'b01000 : 5'b00000;
      exp_done  = (c == 4);
      tests_run++; if (stall4 !== exp_stall || flush4 !== exp_flush) begin tests_failed++; $display("FAIL div_c%0d_stall: got stall=%b flush=%b expected %b %b", c, stall4, flush4, exp_stall, exp_flush); end
      tests_run++; if (done4 !== exp_done) begin tests_failed++; $display("FAIL div_c%0d_done: got %b expected %b", c, done4, exp_done); end
      step();
    end
    exe_div_start = 1'b0;
  endtask

  task automatic test_mem_wait_div();
    for (int c = 0; c < 8; c++) begin
      exe_div_start = (c == 0);
      mem_bus_wait  = (c == 1) || (c == 2);
      @(negedge clk);
      if (c == 1 || c == 2) begin
        exp_stall = 5'b01111; exp_flush = 5'b10000;
      end else if (c < 6) begin
        exp_stall = 5'b00111; exp_flush = 5'b01000;
      end else begin
        exp_stall = 5'b00000; exp_flush = 5'b00000;
      end
      exp_done = (c == 6);
      tests_run++; if (stall4 !== exp_stall || flush4 !== exp_flush) begin tests_failed++; $display("FAIL memwait_c%0d_stall: got stall=%b flush=%b expected %b %b", c, stall4, flush4, exp_stall, exp_flush); end
      tests_run++; if (done4 !== exp_done) begin tests_failed++; $display("FAIL memwait_c%0d_done: got %b expected %b", c, done4, exp_done); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_excp_mid_div();
    for (int c = 0; c < 9; c++) begin
      exe_div_start = (c == 0);
      excp_valid    = (c == 2);
      id_load_use   = (c == 3);
      @(negedge clk);
      if (c == 2) begin
        tests_run++; if (flush4 !== 5'b11110 || stall4 !== 5'b0) begin tests_failed++; $display("FAIL excp_flush: got stall=%b flush=%b expected 00000 11110", stall4, flush4); end
        tests_run++; if (npcv4 !== 1'b1 || npc4 !== 32'hBFC0_0380) begin tests_failed++; $display("FAIL excp_pc: got v=%b pc=%h expected v=1 pc=bfc00380", npcv4, npc4); end
      end else if (c >= 3) begin
        tests_run++; if (stall4 !== 5'b0 || flush4 !== 5'b0 || done4 !== 1'b0) begin tests_failed++; $display("FAIL excp_after_c%0d: got stall=%b flush=%b done=%b expected 00000 00000 0", c, stall4, flush4, done4); end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_eret();
    excp_eret = 1'b1;
    cp0_epc   = 32'h8000_1234;
    @(negedge clk);
    tests_run++; if (npcv4 !== 1'b1 || npc4 !== 32'h8000_1234) begin tests_failed++; $display("FAIL eret_pc: got v=%b pc=%h expected v=1 pc=80001234", npcv4, npc4); end
    tests_run++; if (flush4 !== 5'b11110) begin tests_failed++; $display("FAIL eret_flush: got %b expected 11110", flush4); end
    step();
    excp_valid = 1'b1;
    @(negedge clk);
    tests_run++; if (npcv4 !== 1'b1 || npc4 !== 32'hBFC0_0380) begin tests_failed++; $display("FAIL eret_excp_pc: got v=%b pc=%h expected v=1 pc=bfc00380", npcv4, npc4); end
    step();
    clear_inputs();
    mem_bus_wait = 1'b1;
    id_load_use  = 1'b1;
    @(negedge clk);
    tests_run++; if (stall4 !== 5'b01111 || flush4 !== 5'b10000) begin tests_failed++; $display("FAIL hold_memwait: got stall=%b flush=%b expected 01111 10000", stall4, flush4); end
    step();
    clear_inputs();
    @(negedge clk);
    tests_run++; if (stall4 !== 5'b0 || npcv4 !== 1'b0 || npc4 !== 32'd0) begin tests_failed++; $display("FAIL eret_idle: got stall=%b v=%b pc=%h expected 00000 0 00000000", stall4, npcv4, npc4); end
    step();
  endtask

  task automatic test_min_latency();
    for (int c = 0; c < 3; c++) begin
      exe_div_start = (c == 0);
      @(negedge clk);
      exp_stall = (c == 0) ? 5'b00111 : 5'b00000;
      exp_done  = (c == 1);
      tests_run++; if (stall1 !== exp_stall) begin tests_failed++; $display("FAIL lat1_c%0d_stall: got %b expected %b", c, stall1, exp_stall); end
      tests_run++; if (done1 !== exp_done) begin tests_failed++; $display("FAIL lat1_c%0d_done: got %b expected %b", c, done1, exp_done); end
      step();
    end
    exe_div_start = 1'b0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_reset_mid_div();
    exe_div_start = 1'b1;
    step();
    exe_div_start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (stall4 !== 5'b0 || flush4 !== 5'b0 || done4 !== 1'b0 || npcv4 !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_div: got stall=%b flush=%b done=%b v=%b expected all 0", stall4, flush4, done4, npcv4); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++; if (stall4 !== 5'b0 || done4 !== 1'b0) begin tests_failed++; $display("FAIL rst_after_c%0d: got stall=%b done=%b expected 00000 0", c, stall4, done4); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait_div();
    test_excp_mid_div();
    test_eret();
    test_min_latency();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
